// File: rtl/dmem_rsp.sv
// dmem_rsp: memory end of the LSU load/store interface, word-wide SRAM with byte enables.
// Optional DMEM_MISALIGN_SPLIT_EN: misaligned accesses legal, word-crossing ones take two cycles.
`default_nettype none

module dmem_rsp #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 64,
    parameter int                    LSWDTH_LSULEN = 3,
    parameter int                    DMEM_DEPTH    = 1024,
    parameter logic [ADDR_WIDTH-1:0] DMEM_BASE     = 32'h80000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     use_pmem_i,
    output logic                     req_ready_o,
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic [DATA_WIDTH-1:0]    st_dat_i,
    input  logic [LSWDTH_LSULEN-1:0] ls_wdth_i,
    input  logic                     ls_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DATA_WIDTH-1:0]    ld_dat_o,
    output logic                     err_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DMEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH + 1)'(DMEM_DEPTH * BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    st_q;
    logic [LSWDTH_LSULEN-1:0] wdth_q;
    logic                     ls_q;
    logic [DATA_WIDTH-1:0]    lo_word;
    logic [DATA_WIDTH-1:0]    mem [DMEM_DEPTH];

    logic [1:0]              size;
    logic [3:0]              nbytes;
    logic [OFF_W-1:0]        off;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        acc_idx;
    logic [ADDR_WIDTH-1:0]   rel;
    logic                    in_win;
    logic                    size_err;
    logic                    misaligned;
    logic                    crosses_word;
    logic                    last_word;
    logic                    split;
    logic                    align_err;
    logic                    acc_err;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [2*BYTES-1:0]      be_all;
    logic [2*DATA_WIDTH-1:0] wd_all;
    logic [BYTES-1:0]        be_cur;
    logic [DATA_WIDTH-1:0]   wd_cur;
    logic                    wr_en;
    logic [2*DATA_WIDTH-1:0] combined;
    logic [DATA_WIDTH-1:0]   ld_val;
    logic [DATA_WIDTH-1:0]   low_mask;
    logic                    sgn;
    logic [DATA_WIDTH-1:0]   ld_fmt;

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);

    assign size         = wdth_q[1:0];
    assign nbytes       = 4'd1 << size;
    assign off          = addr_q[OFF_W-1:0];
    assign idx          = addr_q[OFF_W +: IDX_W];
    assign rel          = addr_q - DMEM_BASE;
    assign in_win       = (addr_q >= DMEM_BASE) && ({1'b0, rel} < WIN_BYTES);
    assign size_err     = (DATA_WIDTH == 32) && (size == 2'd3);
    assign misaligned   = (addr_q[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0;
    assign crosses_word = (int'(off) + int'(nbytes)) > BYTES;
    assign last_word    = (idx == IDX_W'(DMEM_DEPTH - 1));

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign split     = crosses_word;
    assign align_err = 1'b0;
`else
    // An aligned access never crosses a word, so this only adds coverage of size-D on 32-bit.
    assign split     = 1'b0;
    assign align_err = misaligned | crosses_word;
`endif

    // The word after the last one wraps outside the window, so a crossing there is an error.
    assign acc_err = !in_win || size_err || align_err || (split && last_word);
    assign acc_idx = (state == ACC1) ? idx + IDX_W'(1) : idx;
    assign rd_word = mem[acc_idx];

    assign be_all = ~({(2*BYTES){1'b1}} << nbytes) << off;
    assign wd_all = {{DATA_WIDTH{1'b0}}, st_q} << {off, 3'b000};
    assign be_cur = (state == ACC1) ? be_all[2*BYTES-1:BYTES] : be_all[BYTES-1:0];
    assign wd_cur = (state == ACC1) ? wd_all[2*DATA_WIDTH-1:DATA_WIDTH] : wd_all[DATA_WIDTH-1:0];
    assign wr_en  = ls_q && !acc_err && ((state == ACC0) || (state == ACC1));

    assign combined = (state == ACC1) ? {rd_word, lo_word} : {{DATA_WIDTH{1'b0}}, rd_word};

    always_comb begin
        int nbits;
        logic [2*DATA_WIDTH-1:0] shifted;
        nbits    = 8 * int'(nbytes);
        if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
        shifted  = combined >> {off, 3'b000};
        ld_val   = shifted[DATA_WIDTH-1:0];
        low_mask = ~({DATA_WIDTH{1'b1}} << nbits);
        sgn      = ld_val[nbits-1] & ~wdth_q[2];
        ld_fmt   = (ld_val & low_mask) | ({DATA_WIDTH{sgn}} & ~low_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (use_pmem_i) state_nxt = ACC0;
            ACC0:    state_nxt = (!acc_err && split) ? ACC1 : RESP;
            ACC1:    state_nxt = RESP;
            RESP:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            st_q     <= '0;
            wdth_q   <= '0;
            ls_q     <= 1'b0;
            lo_word  <= '0;
            ld_dat_o <= '0;
            err_o    <= 1'b0;
        end else begin
            if (state == IDLE && use_pmem_i) begin
                addr_q <= addr_i;
                st_q   <= st_dat_i;
                wdth_q <= ls_wdth_i;
                ls_q   <= ls_i;
            end
            if (state == ACC0) begin
                err_o <= acc_err;
                if (acc_err || ls_q) ld_dat_o <= '0;
                else if (split)      lo_word  <= rd_word;
                else                 ld_dat_o <= ld_fmt;
            end
            if (state == ACC1 && !ls_q) ld_dat_o <= ld_fmt;
        end
    end

    // SRAM array: no reset on contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (wr_en && be_cur[b]) mem[acc_idx][b*8 +: 8] <= wd_cur[b*8 +: 8];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_rsp.sv
// Directed bench for dmem_rsp (DATA_WIDTH=64, window at 0x80000000, 8 KiB).
`default_nettype none

module tb_dmem_rsp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        use_pmem = 1'b0;
    logic        req_ready;
    logic [31:0] addr = '0;
    logic [63:0] st_dat = '0;
    logic [2:0]  ls_wdth = '0;
    logic        ls = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] ld_dat;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] W_B = 3'd0, W_H = 3'd1, W_W = 3'd2, W_D = 3'd3;
    localparam logic [2:0] W_BU = 3'd4, W_HU = 3'd5, W_WU = 3'd6;

    dmem_rsp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .use_pmem_i  (use_pmem),
        .req_ready_o (req_ready),
        .addr_i      (addr),
        .st_dat_i    (st_dat),
        .ls_wdth_i   (ls_wdth),
        .ls_i        (ls),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .ld_dat_o    (ld_dat),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One request with rsp_ready held high; lat counts cycles from accept (T) to response.
    task automatic xact(input string tag, input logic [31:0] a, input logic [63:0] d,
                        input logic [2:0] w, input logic s, input int exp_lat,
                        input logic [63:0] exp_dat, input logic exp_err);
        int lat;
        @(negedge clk);
        check_val({tag, "_rdy"}, 64'(req_ready), 64'd1);
        use_pmem  = 1'b1;
        addr      = a;
        st_dat    = d;
        ls_wdth   = w;
        ls        = s;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 use_pmem = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check_val({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_dat"}, ld_dat, exp_dat);
        check_val({tag, "_err"}, 64'(err), 64'(exp_err));
        @(posedge clk);
        #1 check_val({tag, "_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        int          wait_cnt;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_ready", 64'(req_ready), 64'd1);
        check_val("rst_dat", ld_dat, 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        xact("sd_init", 32'h80000010, 64'd0, W_D, 1'b1, 2, 64'd0, 1'b0);
        xact("sw", 32'h80000010, 64'hDEADBEEF, W_W, 1'b1, 2, 64'd0, 1'b0);
        xact("lw", 32'h80000010, 64'd0, W_W, 1'b0, 2, 64'hFFFFFFFF_DEADBEEF, 1'b0);
        xact("lwu", 32'h80000010, 64'd0, W_WU, 1'b0, 2, 64'h00000000_DEADBEEF, 1'b0);

        xact("sb", 32'h80000013, 64'h7F, W_B, 1'b1, 2, 64'd0, 1'b0);
        xact("lwu2", 32'h80000010, 64'd0, W_WU, 1'b0, 2, 64'h7FADBEEF, 1'b0);
        xact("lb", 32'h80000012, 64'd0, W_B, 1'b0, 2, 64'hFFFFFFFF_FFFFFFAD, 1'b0);
        xact("lh", 32'h80000010, 64'd0, W_H, 1'b0, 2, 64'hFFFFFFFF_FFFFBEEF, 1'b0);
        xact("lhu", 32'h80000012, 64'd0, W_HU, 1'b0, 2, 64'h7FAD, 1'b0);
        xact("lbu", 32'h80000013, 64'd0, W_BU, 1'b0, 2, 64'h7F, 1'b0);
        xact("swu", 32'h80000014, 64'hFFFF_FFFF_1234_5678, W_WU, 1'b1, 2, 64'd0, 1'b0);
        xact("ld", 32'h80000010, 64'd0, W_D, 1'b0, 2, 64'h12345678_7FADBEEF, 1'b0);

`ifndef DMEM_MISALIGN_SPLIT_EN
        xact("lh_mis", 32'h80000011, 64'd0, W_H, 1'b0, 2, 64'd0, 1'b1);
        xact("sh_mis", 32'h80000011, 64'hFFFF, W_H, 1'b1, 2, 64'd0, 1'b1);
        xact("sw_mis", 32'h80000012, 64'hFFFFFFFF, W_W, 1'b1, 2, 64'd0, 1'b1);
        xact("lwu_mis", 32'h80000010, 64'd0, W_WU, 1'b0, 2, 64'h7FADBEEF, 1'b0);
`endif

        // Response stall: outputs held, concurrent request ignored.
        @(negedge clk);
        use_pmem = 1'b1; addr = 32'h80000010; ls_wdth = W_WU; ls = 1'b0; rsp_ready = 1'b0;
        @(posedge clk);
        #1 use_pmem = 1'b0;
        wait_cnt = 0;
        while (!rsp_valid && wait_cnt < 20) begin
            @(posedge clk);
            #1 wait_cnt++;
        end
        held = ld_dat;
        check_val("stall_first", held, 64'h7FADBEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            use_pmem = 1'b1; addr = 32'h80000010; st_dat = 64'd0; ls_wdth = W_D; ls = 1'b1;
            check_val("stall_valid", 64'(rsp_valid), 64'd1);
            check_val("stall_dat", ld_dat, held);
            check_val("stall_rdy", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        use_pmem = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("stall_rel_valid", 64'(rsp_valid), 64'd0);
        check_val("stall_rel_rdy", 64'(req_ready), 64'd1);
        xact("stall_chk", 32'h80000010, 64'd0, W_D, 1'b0, 2, 64'h12345678_7FADBEEF, 1'b0);

        // Reset asserted while the access is in ACC0.
        @(negedge clk);
        use_pmem = 1'b1; addr = 32'h80000010; ls_wdth = W_D; ls = 1'b0;
        @(posedge clk);
        #1 use_pmem = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check_val("mid_rst_dat", ld_dat, 64'd0);
        check_val("mid_rst_err", 64'(err), 64'd0);
        check_val("mid_rst_rdy", 64'(req_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        xact("ld_post_rst", 32'h80000010, 64'd0, W_D, 1'b0, 2, 64'h12345678_7FADBEEF, 1'b0);

        xact("oow_low", 32'h00001000, 64'd0, W_W, 1'b0, 2, 64'd0, 1'b1);
        xact("oow_below", 32'h7FFFFFF8, 64'd0, W_D, 1'b0, 2, 64'd0, 1'b1);
        xact("oow_top", 32'h80002000, 64'd0, W_D, 1'b0, 2, 64'd0, 1'b1);
        xact("sd_last", 32'h80001FF8, 64'hCAFEF00D_12345678, W_D, 1'b1, 2, 64'd0, 1'b0);
        xact("ld_last", 32'h80001FF8, 64'd0, W_D, 1'b0, 2, 64'hCAFEF00D_12345678, 1'b0);

`ifdef DMEM_MISALIGN_SPLIT_EN
        xact("sd_a", 32'h80000020, 64'h11223344_55667788, W_D, 1'b1, 2, 64'd0, 1'b0);
        xact("sd_b", 32'h80000028, 64'd0, W_D, 1'b1, 2, 64'd0, 1'b0);
        xact("lw_cross", 32'h80000026, 64'd0, W_W, 1'b0, 3, 64'h00001122, 1'b0);
        xact("lw_in", 32'h80000022, 64'd0, W_W, 1'b0, 2, 64'h33445566, 1'b0);
        xact("sd_c", 32'h80000030, 64'd0, W_D, 1'b1, 2, 64'd0, 1'b0);
        xact("sw_cross", 32'h8000002E, 64'hAABBCCDD, W_W, 1'b1, 3, 64'd0, 1'b0);
        xact("lw_cross2", 32'h8000002E, 64'd0, W_W, 1'b0, 3, 64'hFFFFFFFF_AABBCCDD, 1'b0);
        xact("lh_mis_ok", 32'h80000011, 64'd0, W_H, 1'b0, 2, 64'hFFFFFFFF_FFFFADBE, 1'b0);
        xact("cross_oow", 32'h80001FFE, 64'd0, W_W, 1'b0, 2, 64'd0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
